pc_sequencer: RTL and testbench

- Consumer end of the instruction-decoder control interface.
- Generates the one-hot machine state (fetch/exec1/exec2) that the decoder consumes.
- Acts on the decoder's program-counter and stack controls (pc_inc, pc_load, jump_mux, stack_mux, push, pop).
- Owns the program counter and the subroutine return-address stack; sits between the decoder and instruction memory in the Harvard, non-pipelined core.

---
 rtl/cpu_ctrl_pkg.sv | 12 +
 rtl/return_stack.sv | 58 +++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: one-hot machine states and the default address width.
package cpu_ctrl_pkg;

   localparam int ADDR_W_DEFAULT = 8;

   typedef logic [2:0] state_t;

   localparam state_t ST_FETCH = 3'b001;
   localparam state_t ST_EXEC1 = 3'b010;
   localparam state_t ST_EXEC2 = 3'b100;

endpackage

// File: rtl/return_stack.sv
// Subroutine return-address LIFO. A push and a pop in the same cycle cancel to a no-op.
// ovf/unf pulse for one cycle when a push hits a full stack or a pop hits an empty one.
module return_stack #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4,
   parameter int LVL_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] tos,
   output logic [LVL_W-1:0]  level,
   output logic              full,
   output logic              empty,
   output logic              ovf,
   output logic              unf
);

   localparam int PTR_W = $clog2(STACK_DEPTH);

   logic [ADDR_W-1:0] mem [0:STACK_DEPTH-1];
   logic [PTR_W-1:0]  wr_idx;
   logic [PTR_W-1:0]  rd_idx;
   logic              do_push;
   logic              do_pop;

   // Status, write/read pointers and the combinational top-of-stack view.
   always_comb begin
      full    = (level == LVL_W'(STACK_DEPTH));
      empty   = (level == '0);
      do_push = push && !pop && !full;
      do_pop  = pop && !push && !empty;
      ovf     = push && !pop && full;
      unf     = pop && !push && empty;
      wr_idx  = PTR_W'(level);
      rd_idx  = PTR_W'(level - LVL_W'(1));
      tos     = empty ? '0 : mem[rd_idx];
   end

   // Occupancy counter; the only stack state that needs a reset.
   always_ff @(posedge clk) begin
      if (!rst_n)
         level <= '0;
      else if (do_push)
         level <= level + LVL_W'(1);
      else if (do_pop)
         level <= level - LVL_W'(1);
   end

   // Entry storage; stale entries above level are never observed.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_idx] <= din;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/exec1/exec2 ring, program counter and error flags for the non-pipelined core.
// Decoder controls are acted on only in the state where they are legal; anything else
// is ignored and latched into proto_err.
module pc_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int              ADDR_W      = ADDR_W_DEFAULT,
   parameter int              STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int              LVL_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic [2:0]        state,
   input  logic              pc_inc,
   input  logic              pc_load,
   input  logic              jump_mux,
   input  logic              stack_mux,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] target_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] tos,
   output logic [LVL_W-1:0]  stack_level,
   output logic              stack_ovf,
   output logic              stack_unf,
   output logic              proto_err
);

   state_t            state_q;
   state_t            state_d;
   logic              load_pending_q;
   logic              in_fetch;
   logic              in_exec1;
   logic              in_exec2;
   logic              take_jump;
   logic              do_inc;
   logic              stk_push;
   logic              stk_pop;
   logic              illegal;
   logic              stk_full;
   logic              stk_empty;
   logic              stk_ovf_pulse;
   logic              stk_unf_pulse;
   logic [ADDR_W-1:0] jump_src;
   logic [ADDR_W-1:0] pc_d;

   return_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH),
      .LVL_W       (LVL_W)
   ) u_stack (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (pc + ADDR_W'(1)),
      .tos   (tos),
      .level (stack_level),
      .full  (stk_full),
      .empty (stk_empty),
      .ovf   (stk_ovf_pulse),
      .unf   (stk_unf_pulse)
   );

   // State register: the ring advances one step per enabled clock.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_FETCH;
      else
         state_q <= state_d;
   end

   // Next state: fetch -> exec1 -> exec2 -> fetch, held while run is low.
   always_comb begin
      state_d = state_q;
      if (run) begin
         case (state_q)
            ST_FETCH: state_d = ST_EXEC1;
            ST_EXEC1: state_d = ST_EXEC2;
            ST_EXEC2: state_d = ST_FETCH;
            default:  state_d = ST_FETCH;
         endcase
      end
   end

   // Output decode: qualify decoder controls by state and pick the next PC.
   always_comb begin
      state     = state_q;
      in_fetch  = (state_q == ST_FETCH);
      in_exec1  = (state_q == ST_EXEC1);
      in_exec2  = (state_q == ST_EXEC2);
      illegal   = run && ((pc_inc && !(in_fetch || in_exec2)) ||
                          ((pc_load || push || pop) && !in_exec1) ||
                          (in_exec1 && (pc_load != jump_mux)) ||
                          (in_exec1 && push && pop));
      take_jump = run && in_exec1 && pc_load && jump_mux;
      stk_push  = run && in_exec1 && push && !pop;
      stk_pop   = run && in_exec1 && pop && !push;
      do_inc    = run && pc_inc && (in_fetch || (in_exec2 && !load_pending_q));
      // The source is sampled before the pop lands; an empty stack returns to RESET_PC.
      jump_src  = stack_mux ? (stk_empty ? RESET_PC : tos) : target_addr;
      pc_d      = pc;
      if (take_jump)
         pc_d = jump_src;
      else if (do_inc)
         pc_d = pc + ADDR_W'(1);
   end

   // PC, load_pending and sticky error flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc             <= RESET_PC;
         load_pending_q <= 1'b0;
         stack_ovf      <= 1'b0;
         stack_unf      <= 1'b0;
         proto_err      <= 1'b0;
      end else begin
         pc <= pc_d;
         if (take_jump)
            load_pending_q <= 1'b1;
         else if (run && in_exec2)
            load_pending_q <= 1'b0;
         if (stk_ovf_pulse)
            stack_ovf <= 1'b1;
         if (stk_unf_pulse)
            stack_unf <= 1'b1;
         if (illegal)
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one task per scenario, inline expected values.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic [2:0] state;
   logic       pc_inc, pc_load, jump_mux, stack_mux, push, pop;
   logic [7:0] target_addr;
   logic [7:0] pc;
   logic [7:0] tos;
   logic [2:0] stack_level;
   logic       stack_ovf, stack_unf, proto_err;

   int checks = 0;
   int passes = 0;

   logic [7:0] nest_tgt [5] = '{8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
   logic [7:0] ret_exp  [4] = '{8'h72, 8'h62, 8'h52, 8'h14};

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .state       (state),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .jump_mux    (jump_mux),
      .stack_mux   (stack_mux),
      .push        (push),
      .pop         (pop),
      .target_addr (target_addr),
      .pc          (pc),
      .tos         (tos),
      .stack_level (stack_level),
      .stack_ovf   (stack_ovf),
      .stack_unf   (stack_unf),
      .proto_err   (proto_err)
   );

   // Apply one cycle of decoder controls, clock once, then sample 1 ns after the edge.
   task automatic cyc(input logic i, input logic l, input logic j, input logic s,
                      input logic pu, input logic po, input logic [7:0] t);
      pc_inc = i; pc_load = l; jump_mux = j; stack_mux = s; push = pu; pop = po;
      target_addr = t;
      @(posedge clk);
      #1;
      pc_inc = 0; pc_load = 0; jump_mux = 0; stack_mux = 0; push = 0; pop = 0;
      target_addr = 8'h00;
   endtask

   task automatic test_reset();
      rst_n = 0; run = 1;
      cyc(0, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (state !== 3'b001) $display("FAIL reset_state got %b exp 001", state); else passes++;
      checks++; if (pc !== 8'h00) $display("FAIL reset_pc got %h exp 00", pc); else passes++;
      checks++; if (stack_level !== 3'd0) $display("FAIL reset_level got %0d exp 0", stack_level); else passes++;
      checks++; if (tos !== 8'h00) $display("FAIL reset_tos got %h exp 00", tos); else passes++;
      checks++; if ({stack_ovf, stack_unf, proto_err} !== 3'b000)
         $display("FAIL reset_flags got %b exp 000", {stack_ovf, stack_unf, proto_err}); else passes++;
      rst_n = 1;
   endtask

   task automatic test_sequential();
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (state !== 3'b010) $display("FAIL seq_state_exec1 got %b exp 010", state); else passes++;
      checks++; if (pc !== 8'h01) $display("FAIL seq_pc_after_fetch got %h exp 01", pc); else passes++;
      cyc(0, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (state !== 3'b100) $display("FAIL seq_state_exec2 got %b exp 100", state); else passes++;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (state !== 3'b001) $display("FAIL seq_state_fetch got %b exp 001", state); else passes++;
      checks++; if (pc !== 8'h02) $display("FAIL seq_pc_after_exec2 got %h exp 02", pc); else passes++;
      for (int n = 0; n < 2; n++) begin
         cyc(1, 0, 0, 0, 0, 0, 8'h00);
         cyc(0, 0, 0, 0, 0, 0, 8'h00);
         cyc(1, 0, 0, 0, 0, 0, 8'h00);
      end
      checks++; if (pc !== 8'h06) $display("FAIL seq_pc_three_instr got %h exp 06", pc); else passes++;
      checks++; if (proto_err !== 1'b0) $display("FAIL seq_no_proto got %b exp 0", proto_err); else passes++;
   endtask

   task automatic test_jms();
      // Plain jump to 0x10 to position the JMS.
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 1, 1, 0, 0, 0, 8'h10);
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (pc !== 8'h10) $display("FAIL jmp_pc got %h exp 10", pc); else passes++;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 1, 1, 0, 1, 0, 8'h40);
      checks++; if (pc !== 8'h40) $display("FAIL jms_pc got %h exp 40", pc); else passes++;
      checks++; if (stack_level !== 3'd1) $display("FAIL jms_level got %0d exp 1", stack_level); else passes++;
      checks++; if (tos !== 8'h12) $display("FAIL jms_tos got %h exp 12", tos); else passes++;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (pc !== 8'h40) $display("FAIL jms_exec2_suppress got %h exp 40", pc); else passes++;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (pc !== 8'h41) $display("FAIL jms_next_fetch got %h exp 41", pc); else passes++;
      cyc(0, 0, 0, 0, 0, 0, 8'h00);
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (pc !== 8'h42) $display("FAIL jms_exec2_inc got %h exp 42", pc); else passes++;
   endtask

   task automatic test_bbl();
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 1, 1, 1, 0, 1, 8'h00);
      checks++; if (pc !== 8'h12) $display("FAIL bbl_pc got %h exp 12", pc); else passes++;
      checks++; if (stack_level !== 3'd0) $display("FAIL bbl_level got %0d exp 0", stack_level); else passes++;
      checks++; if (tos !== 8'h00) $display("FAIL bbl_tos got %h exp 00", tos); else passes++;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (pc !== 8'h12) $display("FAIL bbl_exec2_pc got %h exp 12", pc); else passes++;
   endtask

   task automatic test_nested();
      for (int k = 0; k < 5; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 8'h00);
         cyc(0, 1, 1, 0, 1, 0, nest_tgt[k]);
         if (k == 3) begin
            checks++; if (stack_ovf !== 1'b0) $display("FAIL nest_no_early_ovf got %b exp 0", stack_ovf); else passes++;
         end
         cyc(1, 0, 0, 0, 0, 0, 8'h00);
      end
      checks++; if (stack_ovf !== 1'b1) $display("FAIL nest_ovf got %b exp 1", stack_ovf); else passes++;
      checks++; if (stack_level !== 3'd4) $display("FAIL nest_level got %0d exp 4", stack_level); else passes++;
      checks++; if (pc !== 8'h90) $display("FAIL nest_pc got %h exp 90", pc); else passes++;
      checks++; if (tos !== 8'h72) $display("FAIL nest_tos got %h exp 72", tos); else passes++;
      for (int k = 0; k < 4; k++) begin
         cyc(1, 0, 0, 0, 0, 0, 8'h00);
         cyc(0, 1, 1, 1, 0, 1, 8'h00);
         checks++; if (pc !== ret_exp[k]) $display("FAIL nest_ret%0d_pc got %h exp %h", k, pc, ret_exp[k]); else passes++;
         checks++; if (stack_level !== 3'(3 - k))
            $display("FAIL nest_ret%0d_level got %0d exp %0d", k, stack_level, 3 - k); else passes++;
         cyc(1, 0, 0, 0, 0, 0, 8'h00);
      end
      checks++; if ({stack_unf, proto_err} !== 2'b00)
         $display("FAIL nest_clean got %b exp 00", {stack_unf, proto_err}); else passes++;
   endtask

   task automatic test_underflow();
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (pc !== 8'h15) $display("FAIL unf_pre_pc got %h exp 15", pc); else passes++;
      cyc(0, 1, 1, 1, 0, 1, 8'h00);
      checks++; if (stack_unf !== 1'b1) $display("FAIL unf_flag got %b exp 1", stack_unf); else passes++;
      checks++; if (pc !== 8'h00) $display("FAIL unf_pc got %h exp 00", pc); else passes++;
      checks++; if (stack_level !== 3'd0) $display("FAIL unf_level got %0d exp 0", stack_level); else passes++;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_push_pop();
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 1, 1, 0, 1, 0, 8'h20);
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (proto_err !== 1'b0) $display("FAIL pp_pre_proto got %b exp 0", proto_err); else passes++;
      checks++; if (tos !== 8'h02) $display("FAIL pp_pre_tos got %h exp 02", tos); else passes++;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      cyc(0, 1, 1, 1, 1, 1, 8'h00);
      checks++; if (proto_err !== 1'b1) $display("FAIL pp_proto got %b exp 1", proto_err); else passes++;
      checks++; if (stack_level !== 3'd1) $display("FAIL pp_level got %0d exp 1", stack_level); else passes++;
      checks++; if (pc !== 8'h02) $display("FAIL pp_jump_pc got %h exp 02", pc); else passes++;
      checks++; if (stack_ovf !== 1'b1) $display("FAIL pp_ovf_sticky got %b exp 1", stack_ovf); else passes++;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic test_run_freeze();
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (pc !== 8'h03) $display("FAIL frz_pre_pc got %h exp 03", pc); else passes++;
      run = 0;
      for (int n = 0; n < 3; n++) begin
         cyc(1, 1, 1, 0, 1, 0, 8'h77);
         checks++; if (state !== 3'b010) $display("FAIL frz%0d_state got %b exp 010", n, state); else passes++;
         checks++; if (pc !== 8'h03) $display("FAIL frz%0d_pc got %h exp 03", n, pc); else passes++;
         checks++; if (stack_level !== 3'd1) $display("FAIL frz%0d_level got %0d exp 1", n, stack_level); else passes++;
      end
      run = 1;
      cyc(0, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (state !== 3'b100) $display("FAIL frz_resume_state got %b exp 100", state); else passes++;
      checks++; if (pc !== 8'h03) $display("FAIL frz_resume_pc got %h exp 03", pc); else passes++;
   endtask

   task automatic test_reset_mid();
      rst_n = 0;
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (state !== 3'b001) $display("FAIL rmid_state got %b exp 001", state); else passes++;
      checks++; if (pc !== 8'h00) $display("FAIL rmid_pc got %h exp 00", pc); else passes++;
      checks++; if (stack_level !== 3'd0) $display("FAIL rmid_level got %0d exp 0", stack_level); else passes++;
      checks++; if (tos !== 8'h00) $display("FAIL rmid_tos got %h exp 00", tos); else passes++;
      checks++; if ({stack_ovf, stack_unf, proto_err} !== 3'b000)
         $display("FAIL rmid_flags got %b exp 000", {stack_ovf, stack_unf, proto_err}); else passes++;
      rst_n = 1;
   endtask

   task automatic test_illegal_inc();
      cyc(0, 0, 0, 0, 0, 0, 8'h00);
      cyc(1, 0, 0, 0, 0, 0, 8'h00);
      checks++; if (proto_err !== 1'b1) $display("FAIL ill_inc_proto got %b exp 1", proto_err); else passes++;
      checks++; if (pc !== 8'h00) $display("FAIL ill_inc_pc got %h exp 00", pc); else passes++;
      checks++; if (state !== 3'b100) $display("FAIL ill_inc_state got %b exp 100", state); else passes++;
   endtask

   initial begin
      rst_n = 0; run = 0;
      pc_inc = 0; pc_load = 0; jump_mux = 0; stack_mux = 0; push = 0; pop = 0;
      target_addr = 8'h00;
      test_reset();
      test_sequential();
      test_jms();
      test_bbl();
      test_nested();
      test_underflow();
      test_push_pop();
      test_run_freeze();
      test_reset_mid();
      test_illegal_inc();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
